// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port and the data port. Data accesses win arbitration, but at most
//   MAX_D_BURST consecutive data grants are made while a fetch is waiting.
//   Fetches whose address changed (or whose request was withdrawn) while the
//   memory was busy are dropped without an i_hit.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   i_req      in   fetch request, held while instructions are wanted
//   i_addr     in   fetch address
//   i_hit      out  one-cycle pulse: instr valid for current i_addr
//   instr      out  fetched word, held until the next i_hit
//   Mem_re     in   data read request, held until d_hit
//   Mem_we     in   data write request, held until d_hit (wins over Mem_re)
//   d_addr     in   data address
//   wrt_data   in   store data
//   d_hit      out  one-cycle pulse: data access complete
//   rd_data    out  load result, held until the next d_hit
//   mem_addr   out  memory address (valid while a strobe is high)
//   mem_re     out  memory read strobe
//   mem_we     out  memory write strobe
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_rdy
//   mem_rdy    in   access-complete pulse from memory
module mem_port_arbiter #(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_hit,
  output logic [DATA_W-1:0] instr,
  input  logic              Mem_re,
  input  logic              Mem_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic              d_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_RESP,
    D_RESP
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  state_e              state_q, state_d;
  logic [3:0]          burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                re_q, re_d;
  logic                we_q, we_d;
  logic                ihit_q, ihit_d;
  logic                dhit_q, dhit_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic d_req;
  logic d_grant;
  logic i_fresh;

  always_comb begin
    d_req   = Mem_re | Mem_we;
    // A waiting fetch caps the data burst; with no fetch waiting data always wins.
    d_grant = d_req && (!i_req || (burst_q < BURST_MAX));
    // The fetch result only counts if the processor still wants that address.
    i_fresh = i_req && (i_addr == addr_q);

    state_d = state_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re_d    = re_q;
    we_d    = we_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    instr_d = instr_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (d_grant) begin
          state_d = D_BUSY;
          addr_d  = d_addr;
          wdata_d = wrt_data;
          // Read+write together is a write.
          we_d    = Mem_we;
          re_d    = !Mem_we;
          burst_d = i_req ? burst_q + 4'd1 : '0;
        end else if (i_req) begin
          state_d = I_BUSY;
          addr_d  = i_addr;
          wdata_d = '0;
          re_d    = 1'b1;
          we_d    = 1'b0;
          burst_d = '0;
        end
      end

      D_BUSY: begin
        if (mem_rdy) begin
          if (re_q) begin
            rdata_d = mem_rdata;
          end
          state_d = D_RESP;
          dhit_d  = 1'b1;
          re_d    = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end

      I_BUSY: begin
        if (mem_rdy) begin
          if (i_fresh) begin
            instr_d = mem_rdata;
            state_d = I_RESP;
            ihit_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
          re_d    = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end

      // The completed data request is still asserted during D_RESP, so no
      // grant is made from either response state.
      I_RESP,
      D_RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        re_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign i_hit     = ihit_q;
  assign d_hit     = dhit_q;
  assign instr     = instr_q;
  assign rd_data   = rdata_q;

endmodule
